// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: default widths, dispatch bundle, ROB entry.
// No logic; widths here are the defaults the ROB parameters fall back to.
// Structs are sized from these defaults, so override them here rather than per instance.
package ooo_pkg;

    localparam int DEF_ROB_SIZE_BITS = 4;
    localparam int DEF_PREG_BITS     = 6;

    typedef struct packed {
        logic                         valid;
        logic [DEF_ROB_SIZE_BITS-1:0] rob_num;
        logic [DEF_PREG_BITS-1:0]     dest_reg;
        logic [DEF_PREG_BITS-1:0]     dest_reg_old;
        logic [31:0]                  pc;
    } rob_dispatch_t;

    typedef struct packed {
        logic                     valid;
        logic                     complete;
        logic [DEF_PREG_BITS-1:0] dest_reg;
        logic [DEF_PREG_BITS-1:0] dest_reg_old;
        logic [31:0]              pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: 2-wide allocate, NUM_WB completion ports, 2-wide retire.
// Latency: writeback strobe to ret_valid is 1 cycle; dispatch indices are combinational from tail.
// Backpressure: disp_ready drops when fewer than 2 entries are free (same-cycle retires not credited).
module reorder_buffer
    import ooo_pkg::*;
#(
    parameter int ROB_SIZE_BITS = DEF_ROB_SIZE_BITS,
    parameter int PREG_BITS     = DEF_PREG_BITS,
    parameter int NUM_WB        = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              disp_valid1,
    input  logic [PREG_BITS-1:0]              disp_dest_reg1,
    input  logic [PREG_BITS-1:0]              disp_dest_old1,
    input  logic [31:0]                       disp_pc1,
    input  logic                              disp_valid2,
    input  logic [PREG_BITS-1:0]              disp_dest_reg2,
    input  logic [PREG_BITS-1:0]              disp_dest_old2,
    input  logic [31:0]                       disp_pc2,
    output logic                              disp_ready,
    output logic [ROB_SIZE_BITS-1:0]          disp_rob_num1,
    output logic [ROB_SIZE_BITS-1:0]          disp_rob_num2,
    input  logic [NUM_WB-1:0]                 wb_valid,
    input  logic [NUM_WB*ROB_SIZE_BITS-1:0]   wb_rob_num,
    output logic                              ret_valid1,
    output logic [ROB_SIZE_BITS-1:0]          ret_rob_num1,
    output logic [PREG_BITS-1:0]              ret_dest_reg1,
    output logic [PREG_BITS-1:0]              ret_dest_old1,
    output logic [31:0]                       ret_pc1,
    output logic                              ret_valid2,
    output logic [ROB_SIZE_BITS-1:0]          ret_rob_num2,
    output logic [PREG_BITS-1:0]              ret_dest_reg2,
    output logic [PREG_BITS-1:0]              ret_dest_old2,
    output logic [31:0]                       ret_pc2,
    output logic [ROB_SIZE_BITS:0]            rob_count,
    output logic                              rob_empty,
    output logic                              rob_full
);

    localparam int DEPTH = 2 ** ROB_SIZE_BITS;

    typedef logic [ROB_SIZE_BITS-1:0] idx_t;
    typedef logic [ROB_SIZE_BITS:0]   cnt_t;

    localparam cnt_t CNT_DEPTH    = cnt_t'(DEPTH);
    localparam cnt_t CNT_DEPTH_M2 = cnt_t'(DEPTH - 2);

    rob_entry_t    entries [DEPTH];
    idx_t          head;
    idx_t          tail;
    cnt_t          count;
    idx_t          head_p1;
    idx_t          tail_p1;
    rob_dispatch_t slot1;
    rob_dispatch_t slot2;
    logic [1:0]    n_disp;
    logic [1:0]    n_ret;
    cnt_t          count_next;

    assign head_p1 = head + idx_t'(1);
    assign tail_p1 = tail + idx_t'(1);

    // Dispatch side: slot 2 rides only on an accepted slot 1 so program order stays contiguous.
    always_comb begin
        disp_ready   = (count <= CNT_DEPTH_M2);
        slot1        = '0;
        slot2        = '0;
        slot1.valid        = disp_ready & disp_valid1 & ~flush;
        slot1.rob_num      = tail;
        slot1.dest_reg     = disp_dest_reg1;
        slot1.dest_reg_old = disp_dest_old1;
        slot1.pc           = disp_pc1;
        slot2.valid        = slot1.valid & disp_valid2;
        slot2.rob_num      = tail_p1;
        slot2.dest_reg     = disp_dest_reg2;
        slot2.dest_reg_old = disp_dest_old2;
        slot2.pc           = disp_pc2;
        n_disp = {1'b0, slot1.valid} + {1'b0, slot2.valid};
    end

    assign disp_rob_num1 = slot1.rob_num;
    assign disp_rob_num2 = slot2.rob_num;

    // Retire side: data outputs are zeroed when their slot is not retiring.
    always_comb begin
        ret_valid1 = ~flush & entries[head].valid & entries[head].complete;
        ret_valid2 = ret_valid1 & entries[head_p1].valid & entries[head_p1].complete;

        ret_rob_num1  = ret_valid1 ? head                       : '0;
        ret_dest_reg1 = ret_valid1 ? entries[head].dest_reg     : '0;
        ret_dest_old1 = ret_valid1 ? entries[head].dest_reg_old : '0;
        ret_pc1       = ret_valid1 ? entries[head].pc           : '0;

        ret_rob_num2  = ret_valid2 ? head_p1                       : '0;
        ret_dest_reg2 = ret_valid2 ? entries[head_p1].dest_reg     : '0;
        ret_dest_old2 = ret_valid2 ? entries[head_p1].dest_reg_old : '0;
        ret_pc2       = ret_valid2 ? entries[head_p1].pc           : '0;

        n_ret      = {1'b0, ret_valid1} + {1'b0, ret_valid2};
        count_next = count + cnt_t'(n_disp) - cnt_t'(n_ret);
    end

    assign rob_count = count;
    assign rob_empty = (count == '0);
    assign rob_full  = (count == CNT_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            // Completion marks only live entries; a retire or new allocation of the same slot overrides it.
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i] && entries[wb_rob_num[i*ROB_SIZE_BITS +: ROB_SIZE_BITS]].valid) begin
                    entries[wb_rob_num[i*ROB_SIZE_BITS +: ROB_SIZE_BITS]].complete <= 1'b1;
                end
            end
            if (ret_valid1) begin
                entries[head].valid    <= 1'b0;
                entries[head].complete <= 1'b0;
            end
            if (ret_valid2) begin
                entries[head_p1].valid    <= 1'b0;
                entries[head_p1].complete <= 1'b0;
            end
            if (slot1.valid) begin
                entries[slot1.rob_num] <= '{valid: 1'b1, complete: 1'b0,
                                            dest_reg: slot1.dest_reg,
                                            dest_reg_old: slot1.dest_reg_old,
                                            pc: slot1.pc};
            end
            if (slot2.valid) begin
                entries[slot2.rob_num] <= '{valid: 1'b1, complete: 1'b0,
                                            dest_reg: slot2.dest_reg,
                                            dest_reg_old: slot2.dest_reg_old,
                                            pc: slot2.pc};
            end
            head  <= head + idx_t'(n_ret);
            tail  <= tail + idx_t'(n_disp);
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatches push expected retires into a queue,
// a negedge monitor pops and compares every retire slot the DUT presents.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        disp_valid1, disp_valid2;
    logic [5:0]  disp_dest_reg1, disp_dest_old1, disp_dest_reg2, disp_dest_old2;
    logic [31:0] disp_pc1, disp_pc2;
    logic        disp_ready;
    logic [3:0]  disp_rob_num1, disp_rob_num2;
    logic [2:0]  wb_valid;
    logic [11:0] wb_rob_num;
    logic        ret_valid1, ret_valid2;
    logic [3:0]  ret_rob_num1, ret_rob_num2;
    logic [5:0]  ret_dest_reg1, ret_dest_old1, ret_dest_reg2, ret_dest_old2;
    logic [31:0] ret_pc1, ret_pc2;
    logic [4:0]  rob_count;
    logic        rob_empty, rob_full;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  rn;
        logic [5:0]  dr;
        logic [5:0]  dold;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    reorder_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid1(disp_valid1), .disp_dest_reg1(disp_dest_reg1),
        .disp_dest_old1(disp_dest_old1), .disp_pc1(disp_pc1),
        .disp_valid2(disp_valid2), .disp_dest_reg2(disp_dest_reg2),
        .disp_dest_old2(disp_dest_old2), .disp_pc2(disp_pc2),
        .disp_ready(disp_ready), .disp_rob_num1(disp_rob_num1), .disp_rob_num2(disp_rob_num2),
        .wb_valid(wb_valid), .wb_rob_num(wb_rob_num),
        .ret_valid1(ret_valid1), .ret_rob_num1(ret_rob_num1), .ret_dest_reg1(ret_dest_reg1),
        .ret_dest_old1(ret_dest_old1), .ret_pc1(ret_pc1),
        .ret_valid2(ret_valid2), .ret_rob_num2(ret_rob_num2), .ret_dest_reg2(ret_dest_reg2),
        .ret_dest_old2(ret_dest_old2), .ret_pc2(ret_pc2),
        .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid1 = 1'b0;
        disp_valid2 = 1'b0;
        wb_valid    = '0;
        flush       = 1'b0;
    endtask

    task automatic wb(input logic [2:0] v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        wb_valid   = v;
        wb_rob_num = {c, b, a};
    endtask

    // Drives a dispatch pair; rn is the hand-expected tail, acc says whether it should be accepted.
    task automatic disp(input logic v1, input logic v2, input logic [31:0] pc,
                        input logic [3:0] rn, input logic acc);
        logic [31:0] p2;
        logic [3:0]  rn2;
        exp_t        e;
        p2  = pc + 32'd4;
        rn2 = rn + 4'd1;
        disp_valid1    = v1;
        disp_valid2    = v2;
        disp_pc1       = pc;
        disp_pc2       = p2;
        disp_dest_reg1 = pc[7:2];
        disp_dest_old1 = ~pc[7:2];
        disp_dest_reg2 = p2[7:2];
        disp_dest_old2 = ~p2[7:2];
        #1;
        chk("disp_rob_num1", {28'd0, disp_rob_num1}, {28'd0, rn});
        chk("disp_rob_num2", {28'd0, disp_rob_num2}, {28'd0, rn2});
        if (acc) begin
            e = '{rn: rn, dr: pc[7:2], dold: ~pc[7:2], pc: pc};
            q.push_back(e);
            if (v2) begin
                e = '{rn: rn2, dr: p2[7:2], dold: ~p2[7:2], pc: p2};
                q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: every presented retire must match the oldest outstanding dispatch.
    exp_t me;
    always @(negedge clk) begin
        if (ret_valid1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ret1_unexpected: got rob %0d, expected no retire", ret_rob_num1);
            end else begin
                me = q.pop_front();
                chk("ret1_rob_num", {28'd0, ret_rob_num1}, {28'd0, me.rn});
                chk("ret1_dest_reg", {26'd0, ret_dest_reg1}, {26'd0, me.dr});
                chk("ret1_dest_old", {26'd0, ret_dest_old1}, {26'd0, me.dold});
                chk("ret1_pc", ret_pc1, me.pc);
            end
        end
        if (ret_valid2) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ret2_unexpected: got rob %0d, expected no retire", ret_rob_num2);
            end else begin
                me = q.pop_front();
                chk("ret2_rob_num", {28'd0, ret_rob_num2}, {28'd0, me.rn});
                chk("ret2_dest_reg", {26'd0, ret_dest_reg2}, {26'd0, me.dr});
                chk("ret2_dest_old", {26'd0, ret_dest_old2}, {26'd0, me.dold});
                chk("ret2_pc", ret_pc2, me.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_disp_ready"}, {31'd0, disp_ready}, 32'd1);
        chk({tag, "_rob_empty"}, {31'd0, rob_empty}, 32'd1);
        chk({tag, "_rob_full"}, {31'd0, rob_full}, 32'd0);
        chk({tag, "_rob_count"}, {27'd0, rob_count}, 32'd0);
        chk({tag, "_ret_valid1"}, {31'd0, ret_valid1}, 32'd0);
        chk({tag, "_ret_valid2"}, {31'd0, ret_valid2}, 32'd0);
        chk({tag, "_ret_rob_num1"}, {28'd0, ret_rob_num1}, 32'd0);
        chk({tag, "_ret_dest_old1"}, {26'd0, ret_dest_old1}, 32'd0);
        chk({tag, "_ret_pc1"}, ret_pc1, 32'd0);
        chk({tag, "_disp_rob_num1"}, {28'd0, disp_rob_num1}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wb(3'b000, 4'd0, 4'd0, 4'd0);
        disp_pc1 = '0; disp_pc2 = '0;
        disp_dest_reg1 = '0; disp_dest_old1 = '0; disp_dest_reg2 = '0; disp_dest_old2 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset_state("rst");

        // 1: fill with pairs until full
        for (int k = 0; k < 8; k++) begin
            disp(1'b1, 1'b1, 32'(8 * k), 4'(2 * k), 1'b1);
            tick();
            if (k == 6) begin
                chk("t1_count14", {27'd0, rob_count}, 32'd14);
                chk("t1_ready_at14", {31'd0, disp_ready}, 32'd1);
            end
        end
        idle();
        chk("t1_count16", {27'd0, rob_count}, 32'd16);
        chk("t1_full", {31'd0, rob_full}, 32'd1);
        chk("t1_ready_full", {31'd0, disp_ready}, 32'd0);
        disp(1'b1, 1'b1, 32'h80, 4'd0, 1'b0);
        tick();
        idle();
        chk("t1_blocked_count", {27'd0, rob_count}, 32'd16);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();

        // 2: out-of-order completion, in-order retire
        disp(1'b1, 1'b1, 32'h100, 4'd0, 1'b1);
        tick();
        disp(1'b1, 1'b1, 32'h108, 4'd2, 1'b1);
        tick();
        idle();
        wb(3'b001, 4'd1, 4'd0, 4'd0);
        tick();
        wb_valid = '0;
        chk("t2_no_early_retire", {31'd0, ret_valid1}, 32'd0);
        wb(3'b001, 4'd0, 4'd0, 4'd0);
        tick();
        wb_valid = '0;
        chk("t2_ret_valid1", {31'd0, ret_valid1}, 32'd1);
        chk("t2_ret_valid2", {31'd0, ret_valid2}, 32'd1);
        chk("t2_dest_old1", {26'd0, ret_dest_old1}, 32'h3F);
        chk("t2_dest_old2", {26'd0, ret_dest_old2}, 32'h3E);
        tick();
        chk("t2_count_after_ret", {27'd0, rob_count}, 32'd2);
        wb(3'b011, 4'd2, 4'd3, 4'd0);
        tick();
        wb_valid = '0;
        tick();
        chk("t2_count_drained", {27'd0, rob_count}, 32'd0);

        // 3: walk head to 14, then dispatch and retire across the wrap
        for (int k = 0; k < 5; k++) begin
            disp(1'b1, 1'b1, 32'h200 + 32'(8 * k), 4'(4 + 2 * k), 1'b1);
            tick();
        end
        idle();
        wb(3'b111, 4'd4, 4'd5, 4'd6);   tick();
        wb(3'b111, 4'd7, 4'd8, 4'd9);   tick();
        wb(3'b111, 4'd10, 4'd11, 4'd12); tick();
        wb(3'b001, 4'd13, 4'd0, 4'd0);  tick();
        wb_valid = '0;
        repeat (6) tick();
        chk("t3_drained_count", {27'd0, rob_count}, 32'd0);
        chk("t3_drained_empty", {31'd0, rob_empty}, 32'd1);
        disp(1'b1, 1'b1, 32'h300, 4'd14, 1'b1);
        tick();
        disp(1'b1, 1'b1, 32'h308, 4'd0, 1'b1);
        tick();
        idle();
        wb(3'b111, 4'd14, 4'd15, 4'd0);
        tick();
        wb(3'b001, 4'd1, 4'd0, 4'd0);
        chk("t3_wrap_ret1", {28'd0, ret_rob_num1}, 32'd14);
        chk("t3_wrap_ret2", {28'd0, ret_rob_num2}, 32'd15);
        tick();
        wb_valid = '0;
        chk("t3_wrap_ret1b", {28'd0, ret_rob_num1}, 32'd0);
        chk("t3_wrap_ret2b", {28'd0, ret_rob_num2}, 32'd1);
        tick();
        chk("t3_count_end", {27'd0, rob_count}, 32'd0);

        // 4: simultaneous dispatch/retire at count 14, and blocking at 15
        for (int k = 0; k < 7; k++) begin
            disp(1'b1, 1'b1, 32'h400 + 32'(8 * k), 4'(2 + 2 * k), 1'b1);
            tick();
        end
        idle();
        chk("t4_count14", {27'd0, rob_count}, 32'd14);
        wb(3'b011, 4'd2, 4'd3, 4'd0);
        tick();
        wb_valid = '0;
        chk("t4_retiring2", {31'd0, ret_valid2}, 32'd1);
        chk("t4_ready14", {31'd0, disp_ready}, 32'd1);
        disp(1'b1, 1'b1, 32'h480, 4'd0, 1'b1);
        tick();
        idle();
        chk("t4_count_same", {27'd0, rob_count}, 32'd14);
        disp(1'b1, 1'b0, 32'h490, 4'd2, 1'b1);
        tick();
        idle();
        chk("t4_count15", {27'd0, rob_count}, 32'd15);
        chk("t4_ready15", {31'd0, disp_ready}, 32'd0);
        wb(3'b011, 4'd4, 4'd5, 4'd0);
        tick();
        wb_valid = '0;
        chk("t4_ret_at15", {31'd0, ret_valid2}, 32'd1);
        chk("t4_blocked_while_ret", {31'd0, disp_ready}, 32'd0);
        disp(1'b1, 1'b1, 32'h4A0, 4'd3, 1'b0);
        tick();
        idle();
        chk("t4_count13", {27'd0, rob_count}, 32'd13);
        chk("t4_ready13", {31'd0, disp_ready}, 32'd1);

        // 5: flush beats dispatch, writeback and retire
        wb(3'b001, 4'd6, 4'd0, 4'd0);
        tick();
        wb_valid = '0;
        flush = 1'b1;
        wb(3'b111, 4'd7, 4'd8, 4'd9);
        disp(1'b1, 1'b1, 32'h500, 4'd3, 1'b0);
        #1;
        chk("t5_flush_no_ret", {31'd0, ret_valid1}, 32'd0);
        tick();
        idle();
        q.delete();
        chk("t5_count0", {27'd0, rob_count}, 32'd0);
        chk("t5_empty", {31'd0, rob_empty}, 32'd1);
        chk("t5_ret_after", {31'd0, ret_valid1}, 32'd0);
        chk("t5_tail0", {28'd0, disp_rob_num1}, 32'd0);
        wb(3'b001, 4'd7, 4'd0, 4'd0);
        tick();
        wb_valid = '0;
        tick();
        chk("t5_stale_wb", {31'd0, ret_valid1}, 32'd0);
        chk("t5_stale_count", {27'd0, rob_count}, 32'd0);
        disp(1'b0, 1'b1, 32'h520, 4'd0, 1'b0);
        tick();
        idle();
        chk("t5_v2_only_ignored", {27'd0, rob_count}, 32'd0);

        // 6: three ports with a duplicate index, then reset mid-stream
        disp(1'b1, 1'b1, 32'h600, 4'd0, 1'b1);
        tick();
        disp(1'b1, 1'b1, 32'h608, 4'd2, 1'b1);
        tick();
        idle();
        wb(3'b111, 4'd2, 4'd2, 4'd3);
        tick();
        wb_valid = '0;
        chk("t6_head_not_done", {31'd0, ret_valid1}, 32'd0);
        wb(3'b011, 4'd0, 4'd1, 4'd0);
        tick();
        wb_valid = '0;
        chk("t6_ret01", {31'd0, ret_valid2}, 32'd1);
        tick();
        chk("t6_ret23", {31'd0, ret_valid2}, 32'd1);
        chk("t6_ret23_num", {28'd0, ret_rob_num1}, 32'd2);
        tick();
        chk("t6_count0", {27'd0, rob_count}, 32'd0);
        disp(1'b1, 1'b1, 32'h700, 4'd4, 1'b1);
        tick();
        idle();
        wb(3'b001, 4'd4, 4'd0, 4'd0);
        tick();
        rst_n = 1'b0;
        wb(3'b010, 4'd0, 4'd5, 4'd0);
        disp(1'b1, 1'b1, 32'h708, 4'd6, 1'b0);
        tick();
        rst_n = 1'b1;
        idle();
        q.delete();
        chk_reset_state("t6_rst");
        tick();
        chk("t6_post_rst_ret", {31'd0, ret_valid1}, 32'd0);
        chk("final_queue_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
